// File: rtl/id_alloc_arbiter.sv
// Purpose: ID remap front-end sharing one 16-entry table between AW/AR allocation and B/R lookup-release.
// Latency: zero-cycle combinational grants and ID translation; counters and pointers update on the rising edge.
// Backpressure: ready is given to one requester per port; a channel at its outstanding limit is skipped, and flush halts allocation while responses continue.
module id_alloc_arbiter #(
    parameter int ID_WIDTH_IN  = 8,
    parameter int ID_WIDTH_OUT = 4,
    parameter int MAX_OUT_W    = 12,
    parameter int MAX_OUT_R    = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [ID_WIDTH_IN-1:0]  aw_id_i,
    output logic [ID_WIDTH_OUT-1:0] aw_id_o,

    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [ID_WIDTH_IN-1:0]  ar_id_i,
    output logic [ID_WIDTH_OUT-1:0] ar_id_o,

    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    input  logic [ID_WIDTH_OUT-1:0] b_id_i,
    output logic [ID_WIDTH_IN-1:0]  b_id_o,

    input  logic                    r_valid_i,
    input  logic                    r_last_i,
    output logic                    r_ready_o,
    input  logic [ID_WIDTH_OUT-1:0] r_id_i,
    output logic [ID_WIDTH_IN-1:0]  r_id_o,

    output logic                    gen_incr_o,
    output logic [ID_WIDTH_IN-1:0]  gen_id_o,
    input  logic                    gen_full_i,
    input  logic [ID_WIDTH_OUT-1:0] gen_id_i,

    output logic                    gen_release_o,
    output logic [ID_WIDTH_OUT-1:0] gen_bid_o,
    input  logic [ID_WIDTH_IN-1:0]  gen_bid_i,
    input  logic                    gen_empty_i,

    input  logic                    flush_i,
    output logic                    flush_done_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [4:0] MAX_W = 5'(MAX_OUT_W);
    localparam logic [4:0] MAX_R = 5'(MAX_OUT_R);

    state_t     state_q, state_d;
    logic       alloc_ptr_q, alloc_ptr_d;   // 0: AW preferred, 1: AR preferred
    logic       rsp_ptr_q, rsp_ptr_d;       // 0: B preferred, 1: R preferred
    logic       r_burst_q, r_burst_d;
    logic [4:0] cnt_w_q, cnt_w_d;
    logic [4:0] cnt_r_q, cnt_r_d;

    logic aw_req, ar_req, grant_aw, grant_ar;
    logic b_req, r_req, sel_b, sel_r, r_rel;

    always_comb begin
        aw_req   = aw_valid_i && (state_q == ST_RUN) && !gen_full_i && (cnt_w_q < MAX_W);
        ar_req   = ar_valid_i && (state_q == ST_RUN) && !gen_full_i && (cnt_r_q < MAX_R);
        grant_aw = aw_req && (!ar_req || !alloc_ptr_q);
        grant_ar = ar_req && (!aw_req ||  alloc_ptr_q);

        aw_ready_o = grant_aw;
        ar_ready_o = grant_ar;
        gen_incr_o = grant_aw || grant_ar;
        gen_id_o   = grant_ar ? ar_id_i : aw_id_i;
        aw_id_o    = gen_id_i;
        ar_id_o    = gen_id_i;

        alloc_ptr_d = alloc_ptr_q;
        if (grant_aw) begin
            alloc_ptr_d = 1'b1;
        end else if (grant_ar) begin
            alloc_ptr_d = 1'b0;
        end

        // B is held off for the whole of an R burst so beats stay contiguous.
        b_req = b_valid_i && !r_burst_q;
        r_req = r_valid_i;
        sel_b = b_req && (!r_req || !rsp_ptr_q);
        sel_r = r_req && (!b_req ||  rsp_ptr_q);
        r_rel = sel_r && r_last_i;

        b_ready_o     = sel_b;
        r_ready_o     = sel_r;
        gen_bid_o     = sel_r ? r_id_i : b_id_i;
        b_id_o        = gen_bid_i;
        r_id_o        = gen_bid_i;
        gen_release_o = sel_b || r_rel;

        rsp_ptr_d = rsp_ptr_q;
        r_burst_d = r_burst_q;
        if (sel_b) begin
            rsp_ptr_d = 1'b1;
        end else if (r_rel) begin
            rsp_ptr_d = 1'b0;
        end
        if (r_rel) begin
            r_burst_d = 1'b0;
        end else if (sel_r) begin
            r_burst_d = 1'b1;
        end

        cnt_w_d = cnt_w_q + {4'd0, grant_aw} - {4'd0, sel_b};
        cnt_r_d = cnt_r_q + {4'd0, grant_ar} - {4'd0, r_rel};

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_i) state_d = ST_DRAIN;
            ST_DRAIN: if (gen_empty_i && (cnt_w_q == 5'd0) && (cnt_r_q == 5'd0)) state_d = ST_HALT;
            ST_HALT:  if (!flush_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        flush_done_o = (state_q == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            alloc_ptr_q <= 1'b0;
            rsp_ptr_q   <= 1'b0;
            r_burst_q   <= 1'b0;
            cnt_w_q     <= 5'd0;
            cnt_r_q     <= 5'd0;
        end else begin
            state_q     <= state_d;
            alloc_ptr_q <= alloc_ptr_d;
            rsp_ptr_q   <= rsp_ptr_d;
            r_burst_q   <= r_burst_d;
            cnt_w_q     <= cnt_w_d;
            cnt_r_q     <= cnt_r_d;
        end
    end

`ifndef SYNTHESIS
    a_cnt_w_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(sel_b && !grant_aw && (cnt_w_q == 5'd0)));
    a_cnt_r_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_rel && !grant_ar && (cnt_r_q == 5'd0)));
    a_cnt_w_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_w_q <= MAX_W);
    a_cnt_r_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_r_q <= MAX_R);
`endif

endmodule

// File: tb/tb_id_alloc_arbiter.sv
// Directed bench for id_alloc_arbiter: arbitration order, limits, bursts, flush and reset.
module tb_id_alloc_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       aw_valid_i, ar_valid_i, b_valid_i, r_valid_i, r_last_i;
    logic [7:0] aw_id_i, ar_id_i;
    logic [3:0] aw_id_o, ar_id_o, b_id_i, r_id_i, gen_id_i, gen_bid_o;
    logic [7:0] b_id_o, r_id_o, gen_id_o, gen_bid_i;
    logic       aw_ready_o, ar_ready_o, b_ready_o, r_ready_o;
    logic       gen_incr_o, gen_full_i, gen_release_o, gen_empty_i;
    logic       flush_i, flush_done_o;

    logic [7:0] tbl [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign gen_bid_i = tbl[gen_bid_o];

    id_alloc_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_id_o(aw_id_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_id_o(ar_id_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_id_i(b_id_i), .b_id_o(b_id_o),
        .r_valid_i(r_valid_i), .r_last_i(r_last_i), .r_ready_o(r_ready_o), .r_id_i(r_id_i), .r_id_o(r_id_o),
        .gen_incr_o(gen_incr_o), .gen_id_o(gen_id_o), .gen_full_i(gen_full_i), .gen_id_i(gen_id_i),
        .gen_release_o(gen_release_o), .gen_bid_o(gen_bid_o), .gen_bid_i(gen_bid_i), .gen_empty_i(gen_empty_i),
        .flush_i(flush_i), .flush_done_o(flush_done_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, then idle all request inputs.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        aw_valid_i = 1'b0; ar_valid_i = 1'b0;
        b_valid_i  = 1'b0; r_valid_i  = 1'b0; r_last_i = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = 8'h40 + 8'(i);
        tbl[3] = 8'hB2;
        tbl[5] = 8'hA1;

        rst_n = 1'b0;
        aw_valid_i = 1'b0; ar_valid_i = 1'b0; b_valid_i = 1'b0; r_valid_i = 1'b0; r_last_i = 1'b0;
        aw_id_i = 8'hA1; ar_id_i = 8'hB2; b_id_i = 4'd0; r_id_i = 4'd0; gen_id_i = 4'd0;
        gen_full_i = 1'b0; gen_empty_i = 1'b0; flush_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1; settle();
        check_eq("rst_flush_done", 32'(flush_done_o), 0);
        check_eq("rst_gen_incr", 32'(gen_incr_o), 0);
        check_eq("rst_gen_release", 32'(gen_release_o), 0);
        check_eq("rst_cnt_w", 32'(dut.cnt_w_q), 0);
        rst_n = 1'b1;
        next_cycle();

        // Alternating grants with both channels always requesting
        for (int k = 0; k < 4; k++) begin
            aw_valid_i = 1'b1; ar_valid_i = 1'b1; gen_id_i = 4'(k + 1);
            settle();
            check_eq("alt_aw_ready", 32'(aw_ready_o), 32'(k % 2 == 0));
            check_eq("alt_ar_ready", 32'(ar_ready_o), 32'(k % 2 == 1));
            check_eq("alt_gen_id", 32'(gen_id_o), (k % 2 == 0) ? 32'hA1 : 32'hB2);
            check_eq("alt_gen_incr", 32'(gen_incr_o), 1);
            check_eq("alt_remap", 32'((k % 2 == 0) ? aw_id_o : ar_id_o), 32'(k + 1));
            next_cycle();
        end
        check_eq("alt_cnt_w", 32'(dut.cnt_w_q), 2);
        check_eq("alt_cnt_r", 32'(dut.cnt_r_q), 2);

        // One B release; response pointer then favours R
        b_valid_i = 1'b1; b_id_i = 4'd5;
        settle();
        check_eq("b1_ready", 32'(b_ready_o), 1);
        check_eq("b1_release", 32'(gen_release_o), 1);
        check_eq("b1_id_o", 32'(b_id_o), 32'hA1);
        next_cycle();

        // 4-beat R burst on ID 3 against a pending B on ID 5
        for (int beat = 1; beat <= 5; beat++) begin
            b_valid_i = 1'b1; b_id_i = 4'd5;
            if (beat <= 4) begin
                r_valid_i = 1'b1; r_id_i = 4'd3; r_last_i = (beat == 4);
            end
            settle();
            check_eq("burst_r_ready", 32'(r_ready_o), 32'(beat <= 4));
            check_eq("burst_b_ready", 32'(b_ready_o), 32'(beat == 5));
            check_eq("burst_release", 32'(gen_release_o), 32'(beat >= 4));
            check_eq("burst_bid_o", 32'(gen_bid_o), (beat <= 4) ? 32'd3 : 32'd5);
            check_eq("burst_id_o", 32'((beat <= 4) ? r_id_o : b_id_o), (beat <= 4) ? 32'hB2 : 32'hA1);
            next_cycle();
        end
        check_eq("burst_cnt_w", 32'(dut.cnt_w_q), 0);
        check_eq("burst_cnt_r", 32'(dut.cnt_r_q), 1);

        r_valid_i = 1'b1; r_last_i = 1'b1; r_id_i = 4'd3;
        settle();
        check_eq("r_single_release", 32'(gen_release_o), 1);
        next_cycle();

        // Fill the write side to its limit
        for (int k = 0; k < 12; k++) begin
            aw_valid_i = 1'b1;
            settle();
            check_eq("fill_aw_ready", 32'(aw_ready_o), 1);
            next_cycle();
        end
        aw_valid_i = 1'b1; ar_valid_i = 1'b1;
        settle();
        check_eq("full_aw_ready", 32'(aw_ready_o), 0);
        check_eq("full_ar_ready", 32'(ar_ready_o), 1);
        next_cycle();
        aw_valid_i = 1'b1; b_valid_i = 1'b1; b_id_i = 4'd7;
        settle();
        check_eq("full_rel_aw_ready", 32'(aw_ready_o), 0);
        check_eq("full_rel_release", 32'(gen_release_o), 1);
        next_cycle();
        aw_valid_i = 1'b1;
        settle();
        check_eq("after_rel_aw_ready", 32'(aw_ready_o), 1);
        next_cycle();

        // Table full blocks all allocation
        gen_full_i = 1'b1; aw_valid_i = 1'b1; ar_valid_i = 1'b1;
        settle();
        check_eq("gfull_aw_ready", 32'(aw_ready_o), 0);
        check_eq("gfull_ar_ready", 32'(ar_ready_o), 0);
        check_eq("gfull_incr", 32'(gen_incr_o), 0);
        next_cycle();
        gen_full_i = 1'b0;

        // Reset in the middle of an R burst
        r_valid_i = 1'b1; r_last_i = 1'b0; r_id_i = 4'd3;
        settle();
        check_eq("mid_r_ready", 32'(r_ready_o), 1);
        next_cycle();
        rst_n = 1'b0;
        settle();
        check_eq("mid_rst_cnt_w", 32'(dut.cnt_w_q), 0);
        check_eq("mid_rst_cnt_r", 32'(dut.cnt_r_q), 0);
        check_eq("mid_rst_flush_done", 32'(flush_done_o), 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        aw_valid_i = 1'b1; ar_valid_i = 1'b1;
        settle();
        check_eq("post_rst_aw_ready", 32'(aw_ready_o), 1);
        check_eq("post_rst_ar_ready", 32'(ar_ready_o), 0);
        next_cycle();
        ar_valid_i = 1'b1;
        settle();
        check_eq("post_rst_ar_alone", 32'(ar_ready_o), 1);
        next_cycle();

        // Flush with two outstanding IDs
        flush_i = 1'b1;
        next_cycle();
        aw_valid_i = 1'b1; ar_valid_i = 1'b1;
        settle();
        check_eq("drain_aw_ready", 32'(aw_ready_o), 0);
        check_eq("drain_ar_ready", 32'(ar_ready_o), 0);
        check_eq("drain_done", 32'(flush_done_o), 0);
        next_cycle();
        b_valid_i = 1'b1; b_id_i = 4'd2;
        settle();
        check_eq("drain_b_ready", 32'(b_ready_o), 1);
        check_eq("drain_b_release", 32'(gen_release_o), 1);
        next_cycle();
        r_valid_i = 1'b1; r_last_i = 1'b1; r_id_i = 4'd4;
        settle();
        check_eq("drain_r_release", 32'(gen_release_o), 1);
        next_cycle();
        gen_empty_i = 1'b1;
        settle();
        check_eq("drain_empty_done", 32'(flush_done_o), 0);
        next_cycle();
        aw_valid_i = 1'b1;
        settle();
        check_eq("halt_done", 32'(flush_done_o), 1);
        check_eq("halt_aw_ready", 32'(aw_ready_o), 0);
        next_cycle();
        flush_i = 1'b0; aw_valid_i = 1'b1;
        settle();
        check_eq("unflush_done", 32'(flush_done_o), 1);
        check_eq("unflush_aw_ready", 32'(aw_ready_o), 0);
        next_cycle();
        aw_valid_i = 1'b1;
        settle();
        check_eq("resume_aw_ready", 32'(aw_ready_o), 1);
        check_eq("resume_done", 32'(flush_done_o), 0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
